cpu1_param_host: RTL
====================

# cpu1_param_host

Parametrised second-generation CPU host core: a 16-bit-instruction, 8-register machine with configurable data and PC widths. It adds a valid/ready instruction handshake, a multi-cycle multiply, a conditional branch, an explicit register output instruction, and resume-from-halt. It sits in the same host-circuit slot as the first-generation CPU host and drives program-counter and register-data observation ports.

## Interface
- DATA_W, 16, register/datapath width (>= 8)
- PC_W, 13, program counter width (>= 12)
- clk  in  1  clock, rising edge
- pon_rst_n_i  in  1  asynchronous, active-low reset
- instruction  in  16  instruction word
- instr_valid  in  1  instruction present
- instr_ready  out  1  core can accept; transfer when instr_valid && instr_ready
- resume_i  in  1  leave HALT state
- pc_out  out  PC_W  current program counter (registered)
- reg_data_out  out  DATA_W  register value from last OUT instruction
- reg_data_vld  out  1  one-cycle pulse when reg_data_out updates
- cpu_halt  out  1  core halted
- busy  out  1  multi-cycle operation in progress

## Operation
- Fields: op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm8 = [7:0], off9 = [8:0] signed.
- Opcodes; unless stated, pc <= pc+1:
  - 0 NOP.
  - 1 ADD: rd = rs1 + rs2.
  - 2 SUB: rd = rs1 - rs2.
  - 3 LDI: rd = zero-extended imm8.
  - 4 JMP: pc <= zero-extended [11:0].
  - 5 BEQZ: if reg[[11:9]] == 0 then pc <= pc + sext(off9), else pc+1.
  - 6 AND. 7 XOR.
  - 8 MUL: rd = low DATA_W bits of rs1*rs2, multi-cycle.
  - 9 OUT: reg_data_out <= reg[rs1], reg_data_vld pulses.
  - F HALT: pc is not changed.
  - A–E: NOP.
- Arithmetic is modulo 2^DATA_W. PC arithmetic is modulo 2^PC_W (wraps).
- FSM states:
  - RUN: instr_ready = 1.
  - MUL: instr_ready = 0, busy = 1.
  - HALT: instr_ready = 0, cpu_halt = 1.
- Transitions:
  - RUN -> MUL on an accepted MUL.
  - MUL -> RUN after DATA_W iterations.
  - RUN -> HALT on an accepted HALT.
  - HALT -> RUN on resume_i, with pc <= pc+1.
- resume_i is ignored outside HALT.
- instr_valid while instr_ready = 0 is not consumed.
- MUL operands are captured at accept; register writes during MUL are impossible.
- rd == rs1 is legal; the source value is the pre-edge value.
- Reset: all registers, pc, and outputs are 0. State is RUN, so instr_ready = 1 and reg_data_vld, cpu_halt, busy = 0.
- Reset in any state, including mid-MUL, aborts immediately with no partial write.

## Timing
- Single-cycle ops: the accepting edge updates the register file, pc, and pc_out (pc_out mirrors the new pc).
- OUT: reg_data_out and reg_data_vld are valid the cycle after the accepting edge; vld is high for exactly one cycle.
- MUL accepted at edge 0:
  - busy is high and instr_ready low from edge 0 through edge DATA_W.
  - rd is written and pc increments at edge DATA_W.
  - instr_ready returns high after edge DATA_W.
- HALT accepted at edge 0: cpu_halt is high after edge 0.
- resume_i sampled high at edge N in HALT: cpu_halt is low and instr_ready high after edge N.

## Configuration
- CPU1_HOST_MUL_EN defined: MUL behaves as above; the multiplier sub-module is instantiated.
- CPU1_HOST_MUL_EN undefined:
  - Opcode 8 is a NOP: pc+1, single cycle.
  - The MUL state is unreachable and busy is tied to 0.
  - No multiplier logic is present.

## Structure
- Package cpu1_host_pkg:
  - Opcode localparams.
  - State enum (RUN, MUL, HALT).
  - Field-position constants.
- Sub-module cpu1_host_mul: iterative shift-add multiplier.
  - Inputs: start and two operands.
  - Outputs: done pulse and product.
  - Exists only under CPU1_HOST_MUL_EN.

## Test plan
- Reset asserted mid-stream -> pc_out = 0, reg_data_out = 0, cpu_halt = 0, busy = 0, instr_ready = 1.
- 0x3205 (LDI R1,5), 0x3403 (LDI R2,3), 0x1650 (ADD R3), 0x90C0 (OUT R3) -> reg_data_out = 8 with a single vld pulse; pc_out = 4.
- R1 = 3, R2 = 5, 0x2650 (SUB R3) then OUT R3 -> 0xFFFE (DATA_W = 16).
- R1 = 7, R2 = 6, 0x8650 (MUL R3):
  - Macro on: instr_ready low for 16 cycles, then R3 = 42.
  - Macro off: R3 unchanged, pc+1 next edge.
  - Reset during MUL: R3 = 0, state RUN.
- At pc = 5, 0x51FE (BEQZ R0, -2) with R0 = 0 -> pc_out = 3.
- 0x4FFF (JMP) -> pc_out = 0x0FFF.
- 0xF000 (HALT) -> cpu_halt = 1; instr_valid is ignored and pc is frozen. resume_i pulse -> cpu_halt = 0, pc+1.

Source files
------------

// File: rtl/cpu1_host_pkg.sv
// Shared definitions for the cpu1_param_host core: opcodes, FSM states and
// instruction field positions. The optional multiplier is selected with the
// CPU1_HOST_MUL_EN macro (see cpu1_param_host.sv).
package cpu1_host_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned REG_IDX_W = 3;

    // Instruction field positions
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_MSB = 8;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_MSB = 5;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned OFF_MSB = 8;
    localparam int unsigned OFF_W   = 9;
    localparam int unsigned JMP_MSB = 11;

    // Opcodes (0xA-0xE decode as NOP)
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_BEQZ = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/cpu1_host_mul.sv
// Iterative shift-add multiplier, one partial product per cycle, DATA_W cycles.
// Only instantiated when CPU1_HOST_MUL_EN is defined.
// Ports:
//   clk, pon_rst_n_i      clock, async active-low reset
//   start_i               capture operands and begin (ignored while running)
//   op_a_i, op_b_i        operands
//   done_c_o              high during the cycle whose edge completes the product
//   product_c_o           low DATA_W bits of op_a*op_b, valid when done_c_o
module cpu1_host_mul #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              pon_rst_n_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              done_c_o,
    output logic [DATA_W-1:0] product_c_o
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              active_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_d;

    // Next accumulator; on the last iteration this is the finished product,
    // so the consumer can write it on the same edge.
    assign acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_c_o = acc_d;
    assign done_c_o    = active_q && (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (active_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_c_o) begin
                active_q <= 1'b0;
            end
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= op_a_i;
            mplier_q <= op_b_i;
        end
    end

endmodule

// File: rtl/cpu1_param_host.sv
// Parametrised 8-register host CPU core with valid/ready instruction intake,
// conditional branch, OUT observation port, halt/resume and optional
// multi-cycle multiply.
// Configuration macro: CPU1_HOST_MUL_EN - when defined, opcode 8 is a
// DATA_W-cycle multiply; when undefined, opcode 8 is a NOP and busy is 0.
// Ports:
//   clk, pon_rst_n_i            clock, async active-low reset
//   instruction, instr_valid    instruction word and its valid
//   instr_ready                 core accepts (RUN state only)
//   resume_i                    leave HALT, pc advances by one
//   pc_out                      current program counter
//   reg_data_out, reg_data_vld  OUT result and its one-cycle strobe
//   cpu_halt, busy              HALT state / multiply in progress
module cpu1_param_host
    import cpu1_host_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 13
) (
    input  logic               clk,
    input  logic               pon_rst_n_i,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               resume_i,
    output logic [PC_W-1:0]    pc_out,
    output logic [DATA_W-1:0]  reg_data_out,
    output logic               reg_data_vld,
    output logic               cpu_halt,
    output logic               busy
);

    state_e                state_q;
    logic [DATA_W-1:0]     rf_q [NUM_REGS];
    logic [PC_W-1:0]       pc_q;
    logic                  instr_ready_q;
    logic                  cpu_halt_q;
    logic [DATA_W-1:0]     reg_data_out_q;
    logic                  reg_data_vld_q;

    logic [3:0]            op;
    logic [REG_IDX_W-1:0]  rd_idx;
    logic [REG_IDX_W-1:0]  rs1_idx;
    logic [REG_IDX_W-1:0]  rs2_idx;
    logic [DATA_W-1:0]     rd_val;
    logic [DATA_W-1:0]     rs1_val;
    logic [DATA_W-1:0]     rs2_val;
    logic                  accept;
    logic [PC_W-1:0]       pc_inc;
    logic [PC_W-1:0]       pc_br;
    logic [PC_W-1:0]       pc_d;
    logic                  alu_we;
    logic [DATA_W-1:0]     alu_res;

    assign op      = instruction[OP_MSB:OP_LSB];
    assign rd_idx  = instruction[RD_MSB:RD_LSB];
    assign rs1_idx = instruction[RS1_MSB:RS1_LSB];
    assign rs2_idx = instruction[RS2_MSB:RS2_LSB];
    assign rd_val  = rf_q[rd_idx];
    assign rs1_val = rf_q[rs1_idx];
    assign rs2_val = rf_q[rs2_idx];
    assign accept  = instr_valid && instr_ready_q;

    // PC arithmetic wraps at 2^PC_W; branch offset is a signed 9-bit field
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_br  = pc_q + {{(PC_W - OFF_W){instruction[OFF_MSB]}}, instruction[OFF_MSB:0]};

    // Single-cycle datapath: register write value and next pc
    always_comb begin
        alu_we  = 1'b0;
        alu_res = '0;
        pc_d    = pc_inc;
        case (op)
            OP_ADD:  begin alu_we = 1'b1; alu_res = rs1_val + rs2_val; end
            OP_SUB:  begin alu_we = 1'b1; alu_res = rs1_val - rs2_val; end
            OP_LDI:  begin alu_we = 1'b1; alu_res = DATA_W'(instruction[IMM_MSB:0]); end
            OP_AND:  begin alu_we = 1'b1; alu_res = rs1_val & rs2_val; end
            OP_XOR:  begin alu_we = 1'b1; alu_res = rs1_val ^ rs2_val; end
            OP_JMP:  pc_d = PC_W'(instruction[JMP_MSB:0]);
            OP_BEQZ: pc_d = (rd_val == '0) ? pc_br : pc_inc;
            OP_HALT: pc_d = pc_q;
            default: ;
        endcase
    end

`ifdef CPU1_HOST_MUL_EN
    logic                 busy_q;
    logic [REG_IDX_W-1:0] mul_rd_q;
    logic                 mul_start;
    logic                 mul_done_c;
    logic [DATA_W-1:0]    mul_product_c;

    assign mul_start = accept && (op == OP_MUL);
    assign busy      = busy_q;

    cpu1_host_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk         (clk),
        .pon_rst_n_i (pon_rst_n_i),
        .start_i     (mul_start),
        .op_a_i      (rs1_val),
        .op_b_i      (rs2_val),
        .done_c_o    (mul_done_c),
        .product_c_o (mul_product_c)
    );
`else
    assign busy = 1'b0;
`endif

    // Control FSM, register file, pc and registered outputs
    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            state_q        <= ST_RUN;
            pc_q           <= '0;
            instr_ready_q  <= 1'b1;
            cpu_halt_q     <= 1'b0;
            reg_data_out_q <= '0;
            reg_data_vld_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf_q[i] <= '0;
            end
`ifdef CPU1_HOST_MUL_EN
            busy_q         <= 1'b0;
            mul_rd_q       <= '0;
`endif
        end else begin
            reg_data_vld_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (alu_we) begin
                            rf_q[rd_idx] <= alu_res;
                        end
                        if (op == OP_OUT) begin
                            reg_data_out_q <= rs1_val;
                            reg_data_vld_q <= 1'b1;
                        end
                        if (op == OP_HALT) begin
                            state_q       <= ST_HALT;
                            instr_ready_q <= 1'b0;
                            cpu_halt_q    <= 1'b1;
                        end
`ifdef CPU1_HOST_MUL_EN
                        // pc holds until the product is written
                        else if (op == OP_MUL) begin
                            state_q       <= ST_MUL;
                            instr_ready_q <= 1'b0;
                            busy_q        <= 1'b1;
                            mul_rd_q      <= rd_idx;
                        end
`endif
                        else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume_i) begin
                        state_q       <= ST_RUN;
                        pc_q          <= pc_inc;
                        instr_ready_q <= 1'b1;
                        cpu_halt_q    <= 1'b0;
                    end
                end
`ifdef CPU1_HOST_MUL_EN
                ST_MUL: begin
                    if (mul_done_c) begin
                        state_q        <= ST_RUN;
                        rf_q[mul_rd_q] <= mul_product_c;
                        pc_q           <= pc_inc;
                        instr_ready_q  <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q       <= ST_RUN;
                    instr_ready_q <= 1'b1;
                    cpu_halt_q    <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready  = instr_ready_q;
    assign pc_out       = pc_q;
    assign reg_data_out = reg_data_out_q;
    assign reg_data_vld = reg_data_vld_q;
    assign cpu_halt     = cpu_halt_q;

endmodule
